fpu_sqrt_iter: RTL and testbench
================================

# fpu_sqrt_iter

Parametrised, multi-cycle floating-point square-root unit with valid/ready handshakes. It accepts an IEEE-style operand of configurable exponent and mantissa width and normalises denormals before iterating. It retires a configurable number of root bits per cycle using a restoring algorithm. Output is an unrounded mantissa plus guard/round/sticky bits, which feeds the existing FPU rounding stage. Successor to the fixed single-precision sqrt path; it sits in the FPU execute pipeline alongside the other float ops.

## Interface
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1
- MAN_WIDTH, 23, stored fraction width; hidden bit implicit
- ROOT_BITS_PER_CYCLE, 1, root bits retired per ITER cycle; legal 1..4
- TAG_WIDTH, 4, opaque tag carried from input to output
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort: drops any in-flight op
- in_valid  in  1  operand valid
- in_ready  out  1  high only in IDLE
- in_sign, in_exponent, in_mantissa  in  1/EXP_WIDTH/MAN_WIDTH  raw operand fields
- in_mode  in  fpu_round_mode_t  rounding mode, passed through
- in_tag  in  TAG_WIDTH  passed through
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_sign, out_exponent, out_mantissa  out  1/EXP_WIDTH/MAN_WIDTH  biased result, fraction without hidden bit
- out_guard  out  3  {guard, round, sticky}
- out_nan, out_inf, out_zero, out_invalid  out  1 each  special-result flags
- out_mode, out_tag  out  —  captured input values

## Operation
- RB = MAN_WIDTH+4 root bits: 1 integer + MAN_WIDTH fraction + guard + round + 1 extra. ITERS = ceil(RB/ROOT_BITS_PER_CYCLE).
- States: IDLE, PREP, ITER, DONE.
- IDLE: in_ready=1. On in_valid, capture operand, mode and tag.
  - Special case → DONE directly.
  - Otherwise → PREP.
- Special cases, all with out_guard=0:
  - Operand is NaN → out_nan.
  - Negative and nonzero, including -inf → out_nan and out_invalid.
  - ±0 → out_zero with sign preserved.
  - +inf → out_inf.
- PREP:
  - Unbiased exponent e = exp-bias for normal operands. Denormals use e = 1-bias-lz, with the mantissa shifted left by its leading-zero count lz so the hidden bit is 1.
  - If e is odd, the radicand is mantissa<<1 and e is decremented. The radicand is then in [1,4) and the root in [1,2), so no post-normalisation is needed.
  - Result exponent = e/2 + bias, computed as an arithmetic shift on an EXP_WIDTH+2-bit signed value.
  - Clear the remainder and root registers, load ITERS into the counter, then → ITER.
- ITER:
  - Each cycle applies ROOT_BITS_PER_CYCLE chained restoring steps.
  - Each step shifts 2 radicand bits into the remainder, trial-subtracts {root,01}, keeps the difference if it is non-negative, and shifts the root bit in.
  - The counter decrements each cycle. At 1 → DONE.
  - Excess root bits produced in the final cycle when RB is not a multiple of ROOT_BITS_PER_CYCLE are discarded; the root is aligned so that the top RB bits are kept.
- DONE:
  - out_mantissa = root[RB-2:3], guard = root[2], round = root[1], sticky = root[0] | (remainder != 0).
  - Hold all outputs stable until out_ready. The cycle after out_valid&&out_ready → IDLE.
- flush (any state) → IDLE next cycle and out_valid drops. flush takes priority over a simultaneous in or out handshake; the op is lost.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0; all out_* data and flags are 0.
- Normal operand: out_valid rises ITERS+2 cycles after the accepting edge (1 PREP + ITERS ITER + DONE entry). Single precision with RB=27 at 1 bit/cycle gives 29; at 3 bits/cycle gives 11.
- Special operand: out_valid one cycle after the accepting edge.
- Throughput is one op per ITERS+3 cycles with zero back-pressure. There is no overlap: in_ready stays 0 from the accept until the cycle after the output handshake.
- Reset asserted mid-op: immediate return to reset values, no output.

## Structure
- Package fpu_sqrt_iter:
  - State enum.
  - Function computing ITERS and RB from the parameters.
  - Result struct parameterised by widths via localparams in the module.
- fpu_round_mode_t comes from the fpu package. The leading-zero count reuses the fpu_utils counters, extended to a generic-width function placed in fpu_utils.
- One sub-module, fpu_sqrt_iter_step: combinational single restoring step (remainder, root, 2 radicand bits → next remainder, next root). It is instantiated ROOT_BITS_PER_CYCLE times in a generate chain.

## Test plan
- 0x40800000 (4.0), ROOT_BITS_PER_CYCLE=1 → exp 0x80, mantissa 0, guard 3'b000, out_valid exactly 29 cycles after accept.
- 0x40000000 (2.0) → exp 0x7F, mantissa 0x3504F3, guard 3'b001. Repeat at ROOT_BITS_PER_CYCLE=3: same result, latency 11.
- Denormal 0x00000001 → exp 0x34, mantissa 0x3504F3, guard 3'b001 (odd exponent plus lz path).
- Specials:
  - 0xBF800000 → nan+invalid.
  - 0x80000000 → zero, sign=1.
  - 0x7F800000 → inf.
  - 0xFF800000 → nan+invalid.
  - Each with out_valid 1 cycle after accept.
- Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0. Release → in_ready=1 the next cycle. A back-to-back accept then succeeds.
- flush mid-ITER and rst_n low mid-ITER → IDLE next cycle (async for reset), no out_valid. The next op, 9.0 → 3.0 (0x40400000), completes correctly.

Source files
------------

// File: rtl/fpu_sqrt_iter_pkg.sv
// Shared types and sizing helpers for the iterative floating-point square root.
// Also holds the generic leading-zero counter used for denormal normalisation.
package fpu_sqrt_iter_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fpu_round_mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } sqrt_state_t;

    localparam int LZC_MAX = 64;

    // Integer bit + fraction + guard + round + one extra bit feeding sticky.
    function automatic int calc_rb(input int man_w);
        return man_w + 4;
    endfunction

    function automatic int calc_iters(input int man_w, input int bits_per_cycle);
        return (calc_rb(man_w) + bits_per_cycle - 1) / bits_per_cycle;
    endfunction

    // Leading zeros within the low w bits of v; returns w when they are all zero.
    function automatic int lzc(input logic [LZC_MAX-1:0] v, input int w);
        int  n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        for (int i = LZC_MAX - 1; i >= 0; i--) begin
            if (i < w && !hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_sqrt_iter_step.sv
// One restoring square-root step: bring in two radicand bits, trial-subtract
// {root,01}, keep the difference when it does not borrow, shift the root bit in.
module fpu_sqrt_iter_step #(
    parameter int RW = 29,
    parameter int QW = 27
) (
    input  logic [RW-1:0] rem,
    input  logic [QW-1:0] root,
    input  logic [1:0]    rad_bits,
    output logic [RW-1:0] rem_next,
    output logic [QW-1:0] root_next
);
    logic [RW+1:0] sh;
    logic [RW+1:0] trial;
    logic [RW+1:0] diff;
    logic          ok;

    always_comb begin
        sh        = {rem, rad_bits};
        trial     = (RW+2)'({root, 2'b01});
        ok        = (sh >= trial);
        diff      = sh - trial;
        // Remainder stays below 2*root+1, so the top two bits are always zero.
        rem_next  = ok ? RW'(diff) : RW'(sh);
        root_next = QW'({root, ok});
    end

endmodule

// File: rtl/fpu_sqrt_iter.sv
// Multi-cycle IEEE-style square root: special-case decode, denormal normalisation,
// restoring iteration retiring ROOT_BITS_PER_CYCLE bits/cycle, unrounded output with GRS.
module fpu_sqrt_iter
    import fpu_sqrt_iter_pkg::*;
#(
    parameter int EXP_WIDTH           = 8,
    parameter int MAN_WIDTH           = 23,
    parameter int ROOT_BITS_PER_CYCLE = 1,
    parameter int TAG_WIDTH           = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_WIDTH-1:0] in_exponent,
    input  logic [MAN_WIDTH-1:0] in_mantissa,
    input  fpu_round_mode_t      in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [EXP_WIDTH-1:0] out_exponent,
    output logic [MAN_WIDTH-1:0] out_mantissa,
    output logic [2:0]           out_guard,
    output logic                 out_nan,
    output logic                 out_inf,
    output logic                 out_zero,
    output logic                 out_invalid,
    output fpu_round_mode_t      out_mode,
    output logic [TAG_WIDTH-1:0] out_tag
);
    localparam int BIAS   = 2**(EXP_WIDTH-1) - 1;
    localparam int RB     = calc_rb(MAN_WIDTH);
    localparam int ITERS  = calc_iters(MAN_WIDTH, ROOT_BITS_PER_CYCLE);
    localparam int NSTEPS = ITERS * ROOT_BITS_PER_CYCLE;
    localparam int DROP   = NSTEPS - RB;
    localparam int RW     = NSTEPS + 2;
    localparam int SW     = EXP_WIDTH + 2;
    localparam int MW     = MAN_WIDTH + 1;
    localparam int PADW   = 2*NSTEPS - MW - 1;
    localparam int CW     = $clog2(ITERS + 1);

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exponent;
        logic [MAN_WIDTH-1:0] mantissa;
        logic [2:0]           guard;
        logic                 nan;
        logic                 inf;
        logic                 zero;
        logic                 invalid;
    } result_t;

    sqrt_state_t           state_q, state_d;
    logic                  accept, ld_prep, iter_en, last_iter;
    logic [EXP_WIDTH-1:0]  op_exp;
    logic [MAN_WIDTH-1:0]  op_man;
    fpu_round_mode_t       mode_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    result_t               res_q, spec_res;
    logic                  special;
    logic [RW-1:0]         rem_q;
    logic [NSTEPS-1:0]     root_q;
    logic [2*NSTEPS-1:0]   rad_q, rad_init;
    logic [CW-1:0]         cnt_q;

    // Special operand decode straight off the input fields.
    logic exp_max, exp_zero, man_nz, is_nan, is_zero, is_inf;
    always_comb begin
        exp_max  = &in_exponent;
        exp_zero = ~|in_exponent;
        man_nz   = |in_mantissa;
        is_nan   = exp_max & man_nz;
        is_zero  = exp_zero & ~man_nz;
        is_inf   = exp_max & ~man_nz;
        special  = is_nan | is_zero | is_inf | in_sign;
        // Specials only raise flags; the rounding stage builds the encoding.
        spec_res         = '0;
        spec_res.nan     = is_nan | (in_sign & ~is_zero);
        spec_res.invalid = in_sign & ~is_zero & ~is_nan;
        spec_res.zero    = is_zero;
        spec_res.sign    = is_zero & in_sign;
        spec_res.inf     = is_inf & ~in_sign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = special ? S_DONE : S_PREP;
            S_PREP: state_d = S_ITER;
            S_ITER: if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        accept    = in_valid & in_ready & ~flush;
        ld_prep   = (state_q == S_PREP) & ~flush;
        iter_en   = (state_q == S_ITER) & ~flush;
        last_iter = iter_en & (cnt_q == CW'(1));
    end

    // Normalise, make the exponent even and place the radicand in [1,4).
    logic                 is_den, odd;
    int                   lz;
    logic [MW-1:0]        mant;
    logic [MW:0]          rad_top;
    logic signed [SW-1:0] e_unb, e_adj, e_half;
    logic [EXP_WIDTH-1:0] res_exp;
    always_comb begin
        is_den = ~|op_exp;
        lz     = lzc(LZC_MAX'({1'b0, op_man}), MW);
        if (is_den) begin
            mant  = MW'({1'b0, op_man} << lz);
            e_unb = SW'(1 - BIAS - lz);
        end else begin
            mant  = {1'b1, op_man};
            e_unb = SW'(op_exp) - SW'(BIAS);
        end
        odd      = e_unb[0];
        e_adj    = odd ? e_unb - SW'(1) : e_unb;
        e_half   = e_adj >>> 1;
        res_exp  = EXP_WIDTH'(e_half + SW'(BIAS));
        rad_top  = odd ? {mant, 1'b0} : {1'b0, mant};
        rad_init = {rad_top, {PADW{1'b0}}};
    end

    logic [RW-1:0]     rem_c  [ROOT_BITS_PER_CYCLE+1];
    logic [NSTEPS-1:0] root_c [ROOT_BITS_PER_CYCLE+1];
    assign rem_c[0]  = rem_q;
    assign root_c[0] = root_q;

    for (genvar g = 0; g < ROOT_BITS_PER_CYCLE; g++) begin : g_step
        fpu_sqrt_iter_step #(.RW(RW), .QW(NSTEPS)) u_step (
            .rem      (rem_c[g]),
            .root     (root_c[g]),
            .rad_bits (rad_q[2*NSTEPS-1-2*g -: 2]),
            .rem_next (rem_c[g+1]),
            .root_next(root_c[g+1])
        );
    end

    // Keep the top RB root bits; anything below folds into sticky.
    logic [RB-1:0] aligned;
    logic          sticky, unused_int;
    always_comb begin
        aligned    = RB'(root_c[ROOT_BITS_PER_CYCLE] >> DROP);
        sticky     = aligned[0] | (|rem_c[ROOT_BITS_PER_CYCLE])
                   | (|(root_c[ROOT_BITS_PER_CYCLE] << RB));
        unused_int = aligned[RB-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_exp <= '0;
            op_man <= '0;
            mode_q <= RM_RNE;
            tag_q  <= '0;
            res_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            rad_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                op_exp <= in_exponent;
                op_man <= in_mantissa;
                mode_q <= in_mode;
                tag_q  <= in_tag;
                if (special) res_q <= spec_res;
            end
            if (ld_prep) begin
                rem_q          <= '0;
                root_q         <= '0;
                rad_q          <= rad_init;
                cnt_q          <= CW'(ITERS);
                res_q          <= '0;
                res_q.exponent <= res_exp;
            end
            if (iter_en) begin
                rem_q  <= rem_c[ROOT_BITS_PER_CYCLE];
                root_q <= root_c[ROOT_BITS_PER_CYCLE];
                rad_q  <= rad_q << (2*ROOT_BITS_PER_CYCLE);
                cnt_q  <= cnt_q - CW'(1);
            end
            if (last_iter) begin
                res_q.mantissa <= aligned[RB-2:3];
                res_q.guard    <= {aligned[2], aligned[1], sticky};
            end
        end
    end

    assign out_sign     = res_q.sign;
    assign out_exponent = res_q.exponent;
    assign out_mantissa = res_q.mantissa;
    assign out_guard    = res_q.guard;
    assign out_nan      = res_q.nan;
    assign out_inf      = res_q.inf;
    assign out_zero     = res_q.zero;
    assign out_invalid  = res_q.invalid;
    assign out_mode     = mode_q;
    assign out_tag      = tag_q;

endmodule

// File: tb/tb_fpu_sqrt_iter.sv
// Scoreboard bench for fpu_sqrt_iter: directed single-precision operands on a
// 1-bit/cycle instance and a 3-bit/cycle instance, monitors pop and compare.
module tb_fpu_sqrt_iter;
    import fpu_sqrt_iter_pkg::*;

    logic clk = 1'b0;
    logic rst_n, flush;
    logic in_sign;
    logic [7:0] in_exponent;
    logic [22:0] in_mantissa;
    fpu_round_mode_t in_mode;
    logic [3:0] in_tag;

    logic iv1, ir1, ov1, or1, os1, on1, oinf1, oz1, oinv1;
    logic [7:0] oe1;
    logic [22:0] om1;
    logic [2:0] og1;
    fpu_round_mode_t omd1;
    logic [3:0] ot1;

    logic iv3, ir3, ov3, or3, os3, on3, oinf3, oz3, oinv3;
    logic [7:0] oe3;
    logic [22:0] om3;
    logic [2:0] og3;
    fpu_round_mode_t omd3;
    logic [3:0] ot3;

    always #5 clk = ~clk;

    fpu_sqrt_iter #(.EXP_WIDTH(8), .MAN_WIDTH(23), .ROOT_BITS_PER_CYCLE(1), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
        .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov1), .out_ready(or1),
        .out_sign(os1), .out_exponent(oe1), .out_mantissa(om1), .out_guard(og1),
        .out_nan(on1), .out_inf(oinf1), .out_zero(oz1), .out_invalid(oinv1),
        .out_mode(omd1), .out_tag(ot1));

    fpu_sqrt_iter #(.EXP_WIDTH(8), .MAN_WIDTH(23), .ROOT_BITS_PER_CYCLE(3), .TAG_WIDTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv3), .in_ready(ir3),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
        .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov3), .out_ready(or3),
        .out_sign(os3), .out_exponent(oe3), .out_mantissa(om3), .out_guard(og3),
        .out_nan(on3), .out_inf(oinf3), .out_zero(oz3), .out_invalid(oinv3),
        .out_mode(omd3), .out_tag(ot3));

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
        logic [2:0]  grd;
        logic [3:0]  flags;  // {nan, inf, zero, invalid}
        logic [3:0]  tag;
        logic [2:0]  mode;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seen1 = 0;
    bit seen3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cmp(input string who, input exp_t e, input logic s, input logic [7:0] ex,
                       input logic [22:0] mn, input logic [2:0] g, input logic [3:0] fl,
                       input logic [3:0] tg, input logic [2:0] md);
        chk({who, "_sign"},  64'(s),  64'(e.sign));
        chk({who, "_exp"},   64'(ex), 64'(e.exp));
        chk({who, "_man"},   64'(mn), 64'(e.man));
        chk({who, "_guard"}, 64'(g),  64'(e.grd));
        chk({who, "_flags"}, 64'(fl), 64'(e.flags));
        chk({who, "_tag"},   64'(tg), 64'(e.tag));
        chk({who, "_mode"},  64'(md), 64'(e.mode));
    endtask

    // Caller is at a negedge; the accepting posedge is the next one.
    task automatic issue(input int sel, input logic [31:0] op, input logic [3:0] tag,
                         input fpu_round_mode_t md, input logic s, input logic [7:0] ex,
                         input logic [22:0] mn, input logic [2:0] g, input logic [3:0] fl,
                         input int lat);
        exp_t e;
        int n;
        in_sign = op[31];
        in_exponent = op[30:23];
        in_mantissa = op[22:0];
        in_tag = tag;
        in_mode = md;
        if (sel == 1) iv1 = 1'b1;
        else          iv3 = 1'b1;
        n = 0;
        while (!((sel == 1) ? ir1 : ir3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'((sel == 1) ? ir1 : ir3), 64'(1));
        e.sign = s; e.exp = ex; e.man = mn; e.grd = g; e.flags = fl;
        e.tag = tag; e.mode = md; e.lat = lat; e.acc = cyc + 1;
        if (sel == 1) q1.push_back(e);
        else          q3.push_back(e);
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv3 = 1'b0;
    endtask

    task automatic send(input int sel, input logic [31:0] op, input logic [3:0] tag,
                        input fpu_round_mode_t md, input logic s, input logic [7:0] ex,
                        input logic [22:0] mn, input logic [2:0] g, input logic [3:0] fl,
                        input int lat);
        @(negedge clk);
        issue(sel, op, tag, md, s, ex, mn, g, fl, lat);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q1.size() + q3.size()), 64'(0));
    endtask

    task automatic no_out(input string name, input int cycles);
        int hits;
        hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ov1) hits++;
        end
        chk(name, 64'(hits), 64'(0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ov1) begin
                if (q1.size() == 0) chk("dut1_spurious_valid", 64'(ov1), 64'(0));
                else begin
                    if (!seen1) begin
                        seen1 = 1;
                        chk("dut1_latency", 64'(cyc + 1 - q1[0].acc), 64'(q1[0].lat));
                    end
                    cmp("dut1", q1[0], os1, oe1, om1, og1, {on1, oinf1, oz1, oinv1}, ot1, omd1);
                    if (or1) begin
                        void'(q1.pop_front());
                        seen1 = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ov3) begin
                if (q3.size() == 0) chk("dut3_spurious_valid", 64'(ov3), 64'(0));
                else begin
                    if (!seen3) begin
                        seen3 = 1;
                        chk("dut3_latency", 64'(cyc + 1 - q3[0].acc), 64'(q3[0].lat));
                    end
                    cmp("dut3", q3[0], os3, oe3, om3, og3, {on3, oinf3, oz3, oinv3}, ot3, omd3);
                    if (or3) begin
                        void'(q3.pop_front());
                        seen3 = 0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; iv1 = 1'b0; iv3 = 1'b0; or1 = 1'b1; or3 = 1'b1;
        in_sign = 1'b0; in_exponent = '0; in_mantissa = '0; in_mode = RM_RNE; in_tag = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(ir1), 64'(1));
        chk("rst_out_valid", 64'(ov1), 64'(0));
        chk("rst_exp",       64'(oe1), 64'(0));
        chk("rst_man",       64'(om1), 64'(0));
        chk("rst_guard",     64'(og1), 64'(0));
        chk("rst_flags",     64'({os1, on1, oinf1, oz1, oinv1}), 64'(0));
        chk("rst_tag",       64'(ot1), 64'(0));
        rst_n = 1'b1;

        // Normal operands at 1 bit/cycle: 27 iterations, latency 29.
        send(1, 32'h40800000, 4'h1, RM_RNE, 1'b0, 8'h80, 23'h000000, 3'b000, 4'b0000, 29);
        send(1, 32'h40000000, 4'h2, RM_RTZ, 1'b0, 8'h7F, 23'h3504F3, 3'b001, 4'b0000, 29);
        send(1, 32'h41100000, 4'h3, RM_RUP, 1'b0, 8'h80, 23'h400000, 3'b000, 4'b0000, 29);
        send(1, 32'h00000001, 4'h4, RM_RDN, 1'b0, 8'h34, 23'h3504F3, 3'b001, 4'b0000, 29);

        // Specials go straight to DONE.
        send(1, 32'hBF800000, 4'h5, RM_RMM, 1'b0, 8'h00, 23'h0, 3'b000, 4'b1001, 1);
        send(1, 32'h80000000, 4'h6, RM_RNE, 1'b1, 8'h00, 23'h0, 3'b000, 4'b0010, 1);
        send(1, 32'h7F800000, 4'h7, RM_RTZ, 1'b0, 8'h00, 23'h0, 3'b000, 4'b0100, 1);
        send(1, 32'hFF800000, 4'h8, RM_RUP, 1'b0, 8'h00, 23'h0, 3'b000, 4'b1001, 1);
        send(1, 32'h7FC00000, 4'h9, RM_RNE, 1'b0, 8'h00, 23'h0, 3'b000, 4'b1000, 1);
        wait_drain();

        // 3 bits/cycle: 9 iterations, latency 11, same result.
        send(3, 32'h40000000, 4'hA, RM_RDN, 1'b0, 8'h7F, 23'h3504F3, 3'b001, 4'b0000, 11);
        wait_drain();

        // Back-pressure: outputs hold, in_ready low, then a back-to-back accept.
        or1 = 1'b0;
        send(1, 32'h40800000, 4'hB, RM_RMM, 1'b0, 8'h80, 23'h000000, 3'b000, 4'b0000, 29);
        n = 0;
        while (!ov1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(ov1), 64'(1));
        repeat (10) begin
            chk("bp_in_ready_low", 64'(ir1), 64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 or1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", 64'(ir1), 64'(1));
        chk("bp_out_valid_after", 64'(ov1), 64'(0));
        issue(1, 32'h40000000, 4'hC, RM_RNE, 1'b0, 8'h7F, 23'h3504F3, 3'b001, 4'b0000, 29);
        @(negedge clk);
        chk("b2b_accepted", 64'(ir1), 64'(0));
        wait_drain();

        // Flush mid-ITER drops the op.
        send(1, 32'h40000000, 4'hD, RM_RNE, 1'b0, 8'h7F, 23'h3504F3, 3'b001, 4'b0000, 29);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        q1.delete();
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(ir1), 64'(1));
        chk("flush_out_valid", 64'(ov1), 64'(0));
        no_out("flush_no_out", 40);
        send(1, 32'h41100000, 4'hE, RM_RTZ, 1'b0, 8'h80, 23'h400000, 3'b000, 4'b0000, 29);
        wait_drain();

        // Asynchronous reset mid-ITER.
        send(1, 32'h40000000, 4'hF, RM_RNE, 1'b0, 8'h7F, 23'h3504F3, 3'b001, 4'b0000, 29);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        q1.delete();
        #1;
        chk("arst_in_ready", 64'(ir1), 64'(1));
        chk("arst_out_valid", 64'(ov1), 64'(0));
        chk("arst_exp", 64'(oe1), 64'(0));
        chk("arst_tag", 64'(ot1), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        no_out("arst_no_out", 40);
        send(1, 32'h41100000, 4'h1, RM_RMM, 1'b0, 8'h80, 23'h400000, 3'b000, 4'b0000, 29);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
